// File: rtl/ldpc_decoder.sv
// rtl/ldpc_decoder.sv - pipelined hard-decision bit-flipping decoder for a systematic (16,8) LDPC code
// Optional err_flag output enabled by defining LDPC_ERR_FLAG_EN.
module ldpc_decoder #(
    parameter int MAX_ITER = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    output logic [15:0] data_out
`ifdef LDPC_ERR_FLAG_EN
    ,
    output logic        err_flag
`endif
);

    function automatic logic [7:0] enc(input logic [7:0] d);
        logic [7:0] p;
        p = '0;
        for (int j = 0; j < 8; j++) begin
            p[j] = d[j] ^ d[3'(j + 1)] ^ d[3'(j + 3)];
        end
        return p;
    endfunction

    // One parallel flip pass: info bit i flips on a majority of its checks {i, i-1, i-3}.
    function automatic logic [15:0] bf_iter(input logic [15:0] w);
        logic [7:0] s;
        logic [7:0] d;
        logic       a, b, c;
        s = w[15:8] ^ enc(w[7:0]);
        d = w[7:0];
        for (int i = 0; i < 8; i++) begin
            a = s[i];
            b = s[3'(i - 1)];
            c = s[3'(i - 3)];
            d[i] = w[i] ^ ((a & b) | (a & c) | (b & c));
        end
        return {w[15:8], d};
    endfunction

    logic [15:0] r_stage [0:MAX_ITER];
    logic [15:0] r_data_out;
    logic [7:0]  w_final_info;
    logic [7:0]  w_final_syn;

    assign w_final_info = r_stage[MAX_ITER][7:0];
    assign w_final_syn  = r_stage[MAX_ITER][15:8] ^ enc(w_final_info);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= MAX_ITER; k++) begin
                r_stage[k] <= '0;
            end
            r_data_out <= '0;
        end else begin
            r_stage[0] <= data_in;
            for (int k = 1; k <= MAX_ITER; k++) begin
                r_stage[k] <= bf_iter(r_stage[k-1]);
            end
            // Parity is always regenerated, so the output is a codeword even when decoding fails.
            r_data_out <= {enc(w_final_info), w_final_info};
        end
    end

    assign data_out = r_data_out;

`ifdef LDPC_ERR_FLAG_EN
    logic r_err_flag;
    logic w_multi_syn;

    // Two or more set bits: clearing the lowest set bit leaves something behind.
    assign w_multi_syn = |(w_final_syn & (w_final_syn - 8'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_flag <= 1'b0;
        end else begin
            r_err_flag <= w_multi_syn;
        end
    end

    assign err_flag = r_err_flag;
`else
    logic w_unused_syn;
    assign w_unused_syn = ^w_final_syn;
`endif

endmodule

// File: tb/tb_ldpc_decoder.sv
// tb/tb_ldpc_decoder.sv - directed self-checking bench for ldpc_decoder (MAX_ITER=2 and MAX_ITER=1)
module tb_ldpc_decoder;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic [15:0] data_out1;
`ifdef LDPC_ERR_FLAG_EN
    logic        err_flag;
    logic        err_flag1;
`endif

    int checks;
    int errors;

    ldpc_decoder #(.MAX_ITER(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .data_out (data_out)
`ifdef LDPC_ERR_FLAG_EN
        ,
        .err_flag (err_flag)
`endif
    );

    ldpc_decoder #(.MAX_ITER(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .data_out (data_out1)
`ifdef LDPC_ERR_FLAG_EN
        ,
        .err_flag (err_flag1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] m_enc(input logic [7:0] d);
        logic [7:0] p;
        for (int j = 0; j < 8; j++) begin
            p[j] = d[j] ^ d[(j + 1) % 8] ^ d[(j + 3) % 8];
        end
        return p;
    endfunction

    function automatic logic [15:0] model(input logic [15:0] w, input int iters);
        logic [7:0] r;
        logic [7:0] d;
        int         syn [8];
        int         cnt;
        r = w[15:8];
        d = w[7:0];
        for (int it = 0; it < iters; it++) begin
            for (int j = 0; j < 8; j++) begin
                syn[j] = int'(r[j] ^ d[j] ^ d[(j + 1) % 8] ^ d[(j + 3) % 8]);
            end
            for (int i = 0; i < 8; i++) begin
                cnt = syn[i] + syn[(i + 7) % 8] + syn[(i + 5) % 8];
                if (cnt >= 2) d[i] = ~d[i];
            end
        end
        return {m_enc(d), d};
    endfunction

    function automatic logic model_err(input logic [15:0] w, input int iters);
        logic [15:0] o;
        logic [7:0]  s;
        int          n;
        o = model(w, iters);
        s = w[15:8] ^ m_enc(o[7:0]);
        n = 0;
        for (int j = 0; j < 8; j++) n += int'(s[j]);
        return n >= 2;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        data_in = 16'h1234;
        step(2);
        checks++;
        if (data_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_out got %h exp 0000", data_out);
        end
        checks++;
        if (data_out1 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_out1 got %h exp 0000", data_out1);
        end
`ifdef LDPC_ERR_FLAG_EN
        checks++;
        if (err_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got %b exp 0", err_flag);
        end
`endif
        rst = 1'b0;
        data_in = 16'h0000;
        for (int c = 0; c < 6; c++) begin
            step(1);
            checks++;
            if (data_out !== 16'h0000) begin
                errors++;
                $display("FAIL post_reset_out cycle %0d got %h exp 0000", c, data_out);
            end
        end
    endtask

    task automatic test_held(input string name, input logic [15:0] w, input logic [15:0] exp);
        data_in = w;
        step(3);
        checks++;
        if (data_out === exp && w != exp) begin
            errors++;
            $display("FAIL %s_latency in %h appeared after 3 edges, exp 4", name, w);
        end
        step(1);
        checks++;
        if (data_out !== exp) begin
            errors++;
            $display("FAIL %s in %h got %h exp %h", name, w, data_out, exp);
        end
`ifdef LDPC_ERR_FLAG_EN
        checks++;
        if (err_flag !== 1'b0) begin
            errors++;
            $display("FAIL %s_err in %h got %b exp 0", name, w, err_flag);
        end
`endif
    endtask

    task automatic test_valid_codewords;
        test_held("valid", 16'hA834, 16'hA834);
        test_held("valid", 16'h0000, 16'h0000);
        test_held("valid", 16'hFFFF, 16'hFFFF);
    endtask

    task automatic test_single_info;
        test_held("info_err", 16'h0001, 16'h0000);
        test_held("info_err", 16'hFFF7, 16'hFFFF);
        test_held("info_err", 16'hA830, 16'hA834);
    endtask

    task automatic test_single_parity;
        test_held("parity_err", 16'h0100, 16'h0000);
        test_held("parity_err", 16'hA934, 16'hA834);
    endtask

    task automatic test_back_to_back;
        logic [15:0] seq [6];
        seq = '{16'hA834, 16'h0000, 16'hFFFF, 16'hA834, 16'hFFFF, 16'h0000};
        for (int c = 0; c < 9; c++) begin
            data_in = (c < 6) ? seq[c] : 16'h0000;
            step(1);
            if (c >= 3) begin
                checks++;
                if (data_out !== seq[c-3]) begin
                    errors++;
                    $display("FAIL b2b idx %0d got %h exp %h", c - 3, data_out, seq[c-3]);
                end
            end
        end
    endtask

    task automatic test_scoreboard;
        logic [15:0] words [6];
        words[0] = 16'h1234;
        words[1] = 16'hABCD;
        for (int k = 2; k < 6; k++) words[k] = 16'($urandom);
        for (int k = 0; k < 6; k++) begin
            data_in = words[k];
            step(4);
            checks++;
            if (data_out !== model(words[k], 2)) begin
                errors++;
                $display("FAIL sb_iter2 in %h got %h exp %h", words[k], data_out, model(words[k], 2));
            end
            checks++;
            if (data_out1 !== model(words[k], 1)) begin
                errors++;
                $display("FAIL sb_iter1 in %h got %h exp %h", words[k], data_out1, model(words[k], 1));
            end
            checks++;
            if (data_out[15:8] !== m_enc(data_out[7:0])) begin
                errors++;
                $display("FAIL codeword in %h got %h exp parity %h", words[k], data_out, m_enc(data_out[7:0]));
            end
`ifdef LDPC_ERR_FLAG_EN
            checks++;
            if (err_flag !== model_err(words[k], 2)) begin
                errors++;
                $display("FAIL sb_err in %h got %b exp %b", words[k], err_flag, model_err(words[k], 2));
            end
`endif
        end
        data_in = 16'h1234;
        step(4);
        checks++;
        if (data_out !== 16'h4DDB) begin
            errors++;
            $display("FAIL arb_1234_iter2 got %h exp 4ddb", data_out);
        end
        checks++;
        if (data_out1 !== 16'h19C1) begin
            errors++;
            $display("FAIL arb_1234_iter1 got %h exp 19c1", data_out1);
        end
`ifdef LDPC_ERR_FLAG_EN
        checks++;
        if (err_flag !== 1'b1 || err_flag1 !== 1'b1) begin
            errors++;
            $display("FAIL arb_1234_err got %b%b exp 11", err_flag, err_flag1);
        end
`endif
    endtask

    task automatic test_mid_reset;
        data_in = 16'h0000;
        step(5);
        data_in = 16'hFFF7;
        step(1);
        rst = 1'b1;
        data_in = 16'h0000;
        step(1);
        checks++;
        if (data_out !== 16'h0000 || data_out1 !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset got %h/%h exp 0000", data_out, data_out1);
        end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step(1);
            checks++;
            if (data_out !== 16'h0000 || data_out1 !== 16'h0000) begin
                errors++;
                $display("FAIL mid_reset_flush cycle %0d got %h/%h exp 0000", c, data_out, data_out1);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        data_in = 16'h0000;
        test_reset();
        test_valid_codewords();
        test_single_info();
        test_single_parity();
        test_back_to_back();
        test_scoreboard();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
